// File: rtl/countdown_timer_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_timer_ctrl
//
// Loadable down-counter with start/stop/pause control, optional auto-reload
// and a one-cycle terminal-count pulse.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   load_en      in   write load_val into preset and count (IDLE/PAUSE/DONE)
//   load_val     in   N-bit preset value
//   start        in   begin / resume / restart countdown
//   stop         in   pause countdown
//   auto_reload  in   level: on terminal count reload preset and keep running
//   count        out  registered current count
//   busy         out  registered, high exactly while state is RUN
//   done         out  registered one-cycle pulse after the 1 -> 0 transition
//   state        out  IDLE=00, RUN=01, PAUSE=10, DONE=11
//
// Input priority on every edge is load_en > stop > start, except in RUN
// where load_en has no effect at all.
// ---------------------------------------------------------------------------
module countdown_timer_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_ONES = {N{1'b1}};

  state_t       state_r;
  state_t       state_nx;
  logic [N-1:0] count_r;
  logic [N-1:0] count_nx;
  logic [N-1:0] preset_r;
  logic [N-1:0] preset_nx;
  logic         done_r;
  logic         done_nx;
  logic         busy_r;
  logic         busy_nx;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        // A start with nothing to count is ignored.
        if (load_en) begin
          state_nx = ST_IDLE;
        end else if (stop) begin
          state_nx = ST_IDLE;
        end else if (start && (count_r != CNT_ZERO)) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nx = ST_PAUSE;
        end else if (count_r == CNT_ONE) begin
          // auto_reload is only looked at here, at terminal count.
          state_nx = auto_reload ? ST_RUN : ST_DONE;
        end else if (count_r == CNT_ZERO) begin
          // Extra cycle at zero on the auto-reload path.
          state_nx = (preset_r != CNT_ZERO) ? ST_RUN : ST_DONE;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (load_en) begin
          state_nx = ST_IDLE;
        end else if (stop) begin
          state_nx = ST_PAUSE;
        end else if (start) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (load_en) begin
          state_nx = ST_IDLE;
        end else if (stop) begin
          state_nx = ST_DONE;
        end else if (start && (preset_r != CNT_ZERO)) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_DONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Output / datapath logic: next count, preset, done pulse and busy
  always_comb begin
    count_nx  = count_r;
    preset_nx = preset_r;
    done_nx   = 1'b0;
    case (state_r)
      ST_IDLE, ST_PAUSE: begin
        if (load_en) begin
          preset_nx = load_val;
          count_nx  = load_val;
        end else begin
          count_nx  = count_r;
        end
      end
      ST_RUN: begin
        if (stop) begin
          count_nx = count_r;
        end else if (count_r == CNT_ONE) begin
          count_nx = CNT_ZERO;
          done_nx  = 1'b1;
        end else if (count_r == CNT_ZERO) begin
          // Reload instead of wrapping; a zero preset simply keeps zero.
          count_nx = preset_r;
        end else begin
          count_nx = count_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (load_en) begin
          preset_nx = load_val;
          count_nx  = load_val;
        end else if (stop) begin
          count_nx  = count_r;
        end else if (start && (preset_r != CNT_ZERO)) begin
          count_nx  = preset_r;
        end else begin
          count_nx  = count_r;
        end
      end
      default: begin
        count_nx = CNT_ZERO;
      end
    endcase
    busy_nx = (state_nx == ST_RUN);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= CNT_ZERO;
      preset_r <= CNT_ONES;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      count_r  <= count_nx;
      preset_r <= preset_nx;
      done_r   <= done_nx;
      busy_r   <= busy_nx;
    end
  end

  assign count = count_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign state = state_r;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_ctrl
//
// Table-driven bench: each record holds one cycle of inputs plus the outputs
// expected after the following rising edge. Expected records go into a
// scoreboard queue when the inputs are driven and are popped and compared
// #1 after the edge. Hand-written sequences cover asynchronous reset.
// ---------------------------------------------------------------------------
module tb_countdown_timer_ctrl;

  localparam int N = 8;
  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] SP = 2'b10;
  localparam logic [1:0] SD = 2'b11;

  typedef struct packed {
    logic         ld;
    logic [N-1:0] lv;
    logic         st;
    logic         sp;
    logic         ar;
    logic [N-1:0] ec;
    logic [1:0]   es;
    logic         ed;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_en = 1'b0;
  logic [N-1:0] load_val = 8'h00;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         auto_reload = 1'b0;
  logic [N-1:0] count;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[$];
  vec_t sb_q[$];

  countdown_timer_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ld, input logic [N-1:0] lv,
                              input logic st, input logic sp, input logic ar,
                              input logic [N-1:0] ec, input logic [1:0] es,
                              input logic ed);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ar = ar;
    v.ec = ec; v.es = es; v.ed = ed;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [N-1:0] ec,
                           input logic [1:0] es, input logic ed);
    logic eb;
    eb = (es == SR);
    n_checks++;
    if (count === ec && state === es && done === ed && busy === eb) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got count=%0d state=%0d done=%0b busy=%0b, want count=%0d state=%0d done=%0b busy=%0b",
               name, count, state, done, busy, ec, es, ed, eb);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string name);
    vec_t e;
    load_en = v.ld; load_val = v.lv; start = v.st; stop = v.sp;
    auto_reload = v.ar;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_out(name, e.ec, e.es, e.ed);
  endtask

  initial begin
    // Basic countdown from 5, then restart from DONE
    vecs.push_back(mk(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 8'd5,  SI, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd5,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd4,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd3,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd2,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd1,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b1));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd0,  SD, 1'b0));
    // start in DONE reloads preset; start+stop at 4; load ignored in RUN
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd5,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd4,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd4,  SP, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd4,  SP, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd4,  SR, 1'b0));
    vecs.push_back(mk(1'b1, 8'd99, 1'b0, 1'b0, 1'b0, 8'd3,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd2,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd1,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b1));
    // Load from DONE, countdown from 10 with a three-cycle pause at 7
    vecs.push_back(mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd10, SI, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd10, SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd9,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd8,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd7,  SR, 1'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd7, SP, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd7,  SR, 1'b0));
    for (int c = 6; c >= 1; c--)
      vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'(c), SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b1));
    // Load while paused returns to IDLE
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd10, SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd9,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd9,  SP, 1'b0));
    vecs.push_back(mk(1'b1, 8'd3,  1'b0, 1'b0, 1'b0, 8'd3,  SI, 1'b0));
    // Auto-reload with preset 3: period 4, then drop auto_reload
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd3,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd2,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd1,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  SR, 1'b1));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd3,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd2,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd1,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  SR, 1'b1));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd3,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd2,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd1,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b1));
    // Zero preset: start ignored; preset 1 counts 1,0 without wrapping
    vecs.push_back(mk(1'b1, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  SI, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  SI, 1'b0));
    vecs.push_back(mk(1'b1, 8'd1,  1'b0, 1'b0, 1'b0, 8'd1,  SI, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd1,  SR, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b1));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b0));
    vecs.push_back(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  SD, 1'b0));

    // Reset state, checked while held low across clock edges
    #12;
    check_out("reset_hold", 8'd0, SI, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_edge", 8'd0, SI, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a countdown at 0x80
    apply(mk(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, SI, 1'b0), "ld_81");
    apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h81, SR, 1'b0), "run_81");
    apply(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h80, SR, 1'b0), "run_80");
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 8'd0, SI, 1'b0);
    @(posedge clk);
    #1;
    check_out("rst_no_done", 8'd0, SI, 1'b0);
    rst = 1'b1;
    apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, SI, 1'b0), "start_cnt0");
    // A short run to DONE, then restart from the preset
    apply(mk(1'b1, 8'd2,  1'b0, 1'b0, 1'b0, 8'd2, SI, 1'b0), "ld_2");
    apply(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd2, SR, 1'b0), "run_2");
    apply(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd1, SR, 1'b0), "run_1");
    apply(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0, SD, 1'b1), "run_0");
    apply(mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd2, SR, 1'b0), "restart");
    apply(mk(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd1, SR, 1'b0), "restart_1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
